// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and 50 MHz default timing for button_event_gen.
package button_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2,
    WAIT_REL  = 2'd3
  } state_e;
  localparam int LONG_PRESS_CYCLES_DFLT = 25000000;
  localparam int REPEAT_CYCLES_DFLT     = 5000000;
  localparam int CNT_W_DFLT             = 25;
endpackage

// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into press/release/long/repeat strobes.
// Auto-repeat strobes exist only when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
module button_event_gen
  import button_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DFLT,
  parameter int REPEAT_CYCLES     = REPEAT_CYCLES_DFLT,
  parameter int CNT_W             = CNT_W_DFLT
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_level,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  localparam int MAX_CYC = LONG_PRESS_CYCLES > REPEAT_CYCLES ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  if (LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2 || (longint'(1) << CNT_W) <= longint'(MAX_CYC)) begin : g_bad_cfg
    $error("button_event_gen: illegal timing parameters");
  end
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d, rel_q, rel_d, long_q, long_d, rep_q, rep_d, held_q, held_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    if (!enable) begin
      state_d = btn_level ? WAIT_REL : IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (btn_level) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end
        PRESSED: if (!btn_level) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LONG_PRESS_CYCLES - 1)) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        LONG_HELD: if (!btn_level) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          cnt_d = '0;
        end
`endif
        default: if (!btn_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;
  assign held          = held_q;
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: directed self-checking bench for button_event_gen (LONG=8, REPEAT=4, CNT_W=4).
module tb_button_event_gen;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn, btn_level, enable;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [4:0] obs;
  int checks = 0;
  int errors = 0;
  button_event_gen #(.LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .btn_level(btn_level), .enable(enable),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .held(held)
  );
  always #5 clk = ~clk;
  // Observed vector order: {press, release, long, repeat, held}
  assign obs = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    resetn = 1'b0; btn_level = 1'b0; enable = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_idle got %b want %b", obs, 5'b00000);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_release got %b want %b", obs, 5'b00000);
    end
  endtask
  task automatic test_short_press();
    logic [4:0] exp;
    btn_level = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp = (c == 1) ? 5'b10001 : 5'b00001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL short_hold c=%0d got %b want %b", c, obs, exp);
      end
    end
    btn_level = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL short_release got %b want %b", obs, 5'b01000);
    end
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL short_after got %b want %b", obs, 5'b00000);
    end
  endtask
  task automatic test_long_hold();
    logic [4:0] exp;
    btn_level = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      exp = {c == 1, 1'b0, c == 9, AR && c > 9 && (c - 9) % 4 == 0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_hold c=%0d got %b want %b", c, obs, exp);
      end
    end
    btn_level = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL long_release got %b want %b", obs, 5'b01000);
    end
    tick();
  endtask
  task automatic test_release_at_terminal();
    logic [4:0] exp;
    btn_level = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = (c == 1) ? 5'b10001 : 5'b00001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL term_hold c=%0d got %b want %b", c, obs, exp);
      end
    end
    btn_level = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL term_release got %b want %b", obs, 5'b01000);
    end
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL term_after got %b want %b", obs, 5'b00000);
    end
  endtask
  task automatic test_enable();
    btn_level = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL en_hold got %b want %b", obs, 5'b00001);
    end
    enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL en_off c=%0d got %b want %b", c, obs, 5'b00000);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL en_wait c=%0d got %b want %b", c, obs, 5'b00000);
      end
    end
    btn_level = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL en_drop got %b want %b", obs, 5'b00000);
    end
    btn_level = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10001) begin
      errors++;
      $display("FAIL en_repress got %b want %b", obs, 5'b10001);
    end
    btn_level = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL en_rerelease got %b want %b", obs, 5'b01000);
    end
    tick();
  endtask
  task automatic test_reset_mid_hold();
    btn_level = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10001) begin
      errors++;
      $display("FAIL rst_press got %b want %b", obs, 5'b10001);
    end
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (obs !== 5'b00101) begin
      errors++;
      $display("FAIL rst_long got %b want %b", obs, 5'b00101);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL rst_async got %b want %b", obs, 5'b00000);
    end
    tick();
    resetn = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10001) begin
      errors++;
      $display("FAIL rst_fresh_press got %b want %b", obs, 5'b10001);
    end
    btn_level = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b01000) begin
      errors++;
      $display("FAIL rst_fresh_release got %b want %b", obs, 5'b01000);
    end
  endtask
  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_release_at_terminal();
    test_enable();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumes a clean, debounced active-high button level and converts it into single-cycle game events: press, release, long-press and auto-repeat.
- Sits between the per-button debouncers and the game controller FSM (column select / drop piece).
- Gives the controller edge-accurate, glitch-free strobes.
- One instance per button.

Parameters:
- LONG_PRESS_CYCLES, 25000000: hold time in clk cycles from press to long_pulse (0.5 s at 50 MHz).
- REPEAT_CYCLES, 5000000: period in clk cycles between repeat_pulse strobes after long press.
- CNT_W, 25: counter width. Legal only if 2^CNT_W > max(LONG_PRESS_CYCLES, REPEAT_CYCLES). Both cycle parameters must be >= 2.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; asynchronous, active-low.
- btn_level  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- enable  input  1  1 = generate events; 0 = suppress all events.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on release of an accepted press.
- long_pulse  output  1  one-cycle strobe when hold reaches LONG_PRESS_CYCLES.
- repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES while held past long press.
- held  output  1  level; 1 while an accepted press is in progress.

Behaviour:
- All outputs are registered. Reset (resetn=0, async) clears all outputs, counter = 0, state = IDLE.
- States: IDLE, PRESSED, LONG_HELD, WAIT_REL. Pulse outputs default to 0 every cycle unless set below.
- IDLE:
  - If enable=1 and btn_level=1: go to PRESSED, press_pulse<=1, counter<=0.
  - Latency is 1 cycle: press_pulse is high for the cycle after the sampling edge.
- PRESSED:
  - If btn_level=0: release_pulse<=1, go to IDLE.
  - Else if counter==LONG_PRESS_CYCLES-1: long_pulse<=1, counter<=0, go to LONG_HELD.
  - Else counter<=counter+1.
  - Result: long_pulse rises exactly LONG_PRESS_CYCLES cycles after press_pulse.
- LONG_HELD:
  - If btn_level=0: release_pulse<=1, go to IDLE.
  - Else if counter==REPEAT_CYCLES-1: repeat_pulse<=1, counter<=0.
  - Else counter<=counter+1.
  - First repeat_pulse comes REPEAT_CYCLES cycles after long_pulse, then periodic.
- WAIT_REL: no events. Go to IDLE when btn_level=0 and enable=1.
- Priority:
  - Release beats terminal count on the same edge: only release_pulse, no long/repeat.
  - enable=0 beats everything.
- enable=0 in any state:
  - Next state is WAIT_REL if btn_level=1, else IDLE. Counter<=0, no pulses, no release_pulse.
  - A press held across enable re-assertion never generates press_pulse; the button must be released first.
- held = 1 exactly in PRESSED and LONG_HELD. It is registered with the state, so it rises in the same cycle as press_pulse and falls in the same cycle as release_pulse.
- Counter never wraps: it is cleared on every terminal count and on every state exit.
- At most one pulse output is high in any cycle.
- Reset mid-hold: all outputs drop immediately. After reset is released with btn_level=1, a fresh press_pulse is generated (IDLE accepts it).

Optional Feature:
- Macro BUTTON_EVENT_AUTO_REPEAT_EN.
- Defined: LONG_HELD generates repeat_pulse as above.
- Undefined:
  - repeat_pulse is a constant 0.
  - Counter holds at 0 in LONG_HELD; LONG_HELD only waits for release or enable=0.
  - REPEAT_CYCLES is unused.

Decomposition:
- Shared package button_pkg holds:
  - the 2-bit state encoding (IDLE=0, PRESSED=1, LONG_HELD=2, WAIT_REL=3);
  - default timing constants for 50 MHz (LONG_PRESS_CYCLES, REPEAT_CYCLES, CNT_W).
- No sub-module is warranted: a single FSM plus one counter.

Test Plan (LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4, enable=1 unless stated):
- Reset, btn_level=0: all outputs 0. Assert resetn=0 mid-hold -> held and all pulses 0 immediately, no clock needed.
- btn_level 0->1, held for 3 cycles, then 0 -> press_pulse 1 cycle (held rises with it); release_pulse 1 cycle later; no long_pulse.
- Hold 30 cycles with macro defined -> long_pulse 8 cycles after press_pulse; repeat_pulse at +4, +8, +12, ... after long_pulse; release_pulse on drop.
- Same stimulus, macro undefined -> long_pulse at +8, repeat_pulse never asserted, release_pulse on drop.
- Drop btn_level on the edge where counter==7 in PRESSED -> release_pulse only, long_pulse stays 0.
- Hold, then enable=0 for 2 cycles, then enable=1 while still held -> held falls, no release_pulse, no press_pulse; release then press again -> normal press_pulse.
